fir_xifu_id_queue: RTL and testbench
====================================

# fir_xifu_id_queue

Parametrised decode/issue stage for the FIR XIFU coprocessor. It sits between the CV32E40X XIF issue interface and the XIFU EX stage. It decodes `xfirlw`, `xfirsw` and `xfirdotp`, buffers accepted instructions in a DEPTH-entry issue queue with a valid/ready handshake toward EX, and stalls issue on XIFU-register hazards using a pending-write scoreboard. It replaces the single-register, ready-only ID/EX pipe stage.

## Interface
Parameters:
- `DEPTH`, 2: issue-queue entries, ≥1, any integer.
- `NREGS`, 32: number of XIFU registers; register index width `RW = $clog2(NREGS)`.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous flush of queue and scoreboard.
- `xif_issue_i`  modport  `cv32e40x_if_xif.coproc_issue`  XIF issue channel.
- `id2ex_o`  out  `id2ex_t`  queue head entry; `'0` when queue empty.
- `ex_valid_o`  out  1  head entry valid.
- `ex_ready_i`  in  1  EX consumes head.
- `wb_valid_i`  in  1  EX/WB writes XIFU register `wb_rd_i`.
- `wb_rd_i`  in  RW  written XIFU register index.
- `id2ctrl_o`  out  `id2ctrl_t`  `{issue, id}` notification to controller scoreboard.

## Operation
- Decode when `issue_valid` and opcode == `INSTR_OPCODE`, by funct3:
  - `xfirlw`: accept, writeback, loadstore. Writes `xrd`.
  - `xfirsw`: accept, writeback, loadstore. Reads `xrs2`.
  - `xfirdotp`: accept, no writeback/loadstore. Reads `xrs1`, `xrs2`, `xrd`; writes `xrd`.
  - Anything else: `issue_resp = '0`.
- Entry fields:
  - `base = rs[0]`, `instr`, `rs1`, `rs2`, `rd`, `id`.
  - `xfirlw`: `offset` = sign-extended I-immediate.
  - `xfirsw`: `offset` = sign-extended S-imm[11:5]; `shamt` = S-imm[4:0].
  - `shamt = 0` for all other instructions.
- `issue_ready = !full && !hazard`. `hazard` is evaluated on the decoded instruction only and is 0 for unsupported instructions.
- Handshake: an issue occurs when `issue_valid && issue_ready`.
  - Accepted issue: push the entry; `id2ctrl_o.issue = 1` the same cycle; `id2ctrl_o.id = issue_req.id` always.
  - Rejected issue (accept = 0): no push.
- Hazard: any register the instruction reads or writes has its pending bit set. This covers RAW and WAW.
- Scoreboard: NREGS pending bits.
  - Set `rd` on an accepted `xfirlw`/`xfirdotp` issue.
  - Clear `wb_rd_i` on `wb_valid_i`.
  - Set and clear of the same register in one cycle: set wins.
- Queue: FIFO with head/tail pointers wrapping at DEPTH-1 → 0 and an occupancy counter 0..DEPTH.
  - Pop on `ex_valid_o && ex_ready_i`.
  - `full` is derived from the counter only, so a pop does not free a slot for a same-cycle push.
  - Push and pop in the same cycle with a non-empty queue: count unchanged.
- `clear_i` takes priority over push, pop and scoreboard update. The queue empties and all pending bits clear next cycle. An issue accepted in the `clear_i` cycle is dropped, but `id2ctrl_o` still reports it.

## Timing
- Reset and after clear: queue empty, `ex_valid_o = 0`, `id2ex_o = '0`, all pending bits 0.
- `issue_resp`, `issue_ready` and `id2ctrl_o` are combinational in the issue cycle.
- Push-to-head latency: 1 cycle. An entry pushed into an empty queue sets `ex_valid_o` on the next edge.
- Throughput: 1 instruction/cycle while not full and hazard-free.
- Hazard release: a `wb_valid_i` in cycle N lets a blocked instruction issue in cycle N+1. There is no combinational wb bypass.
- No combinational path exists from `ex_ready_i` to `issue_ready`.
- Asynchronous reset mid-operation discards all entries and pending bits immediately.

## Configuration
- `FIR_XIFU_ID_HAZARD_EN` defined: scoreboard and hazard stall are active as described above.
- Not defined:
  - No scoreboard is built; `hazard = 0`, so `issue_ready = !full`.
  - `wb_valid_i` and `wb_rd_i` are ignored.
  - EX is responsible for ordering.

## Structure
- `fir_xifu_pkg` holds:
  - `instr_t` and the opcode/funct3 constants.
  - `id2ex_t`, extended with `shamt[4:0]`.
  - `id2ctrl_t`.
  - Immediate/field extraction functions.
- Sub-module `fir_xifu_id_fifo` (parameters DEPTH and type T) provides the push/pop/full/empty FIFO. Decode, hazard check and scoreboard live in the top module.

## Test plan
- Reset → `ex_valid_o = 0`, `id2ex_o = '0`, `issue_ready = 1`. Issue `xfirlw x3, 8(rs1 = 0x1000)` → next cycle head has `base = 0x1000`, `offset = 8`, `rd = 3`, `ex_valid_o = 1`.
- `xfirsw` with imm = 0xFE4 → `offset = -1` (0xFFFFFFFF), `shamt = 4`, accept = 1, loadstore = 1.
- DEPTH = 2, `ex_ready_i = 0`, issue 3 independent instructions → third sees `issue_ready = 0`. Raise `ex_ready_i` → first pops, third is accepted one cycle later, FIFO order preserved across pointer wrap.
- HAZARD_EN: `xfirlw x5`, then `xfirdotp x1, x5, x2` → stalled until `wb_valid_i` with `wb_rd_i = 5` in cycle N, issues in N+1. Same-cycle set/clear of x5 → bit remains set.
- Unsupported funct3 → accept = 0, no push, `id2ctrl_o.issue = 0`, `issue_ready = 1`.
- `clear_i` with 2 queued entries and pending x5 → next cycle `ex_valid_o = 0`, x5 no longer pending, dependent instruction issues immediately.

Source files
------------

// File: rtl/fir_xifu_pkg.sv
// FIR XIFU shared types: instruction fields, ID/EX bundle, XIF issue types.
package fir_xifu_pkg;

  localparam logic [6:0] INSTR_OPCODE = 7'b0001011;
  localparam logic [2:0] F3_XFIRLW    = 3'b000;
  localparam logic [2:0] F3_XFIRSW    = 3'b001;
  localparam logic [2:0] F3_XFIRDOTP  = 3'b010;
  localparam int         X_ID_W       = 4;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_t;

  typedef struct packed {
    instr_t            instr;
    logic [31:0]       base;
    logic [31:0]       offset;
    logic [4:0]        shamt;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [X_ID_W-1:0] id;
  } id2ex_t;

  typedef struct packed {
    logic              issue;
    logic [X_ID_W-1:0] id;
  } id2ctrl_t;

  typedef struct packed {
    logic [31:0]       instr;
    logic [1:0][31:0]  rs;
    logic [X_ID_W-1:0] id;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  function automatic logic [31:0] imm_i(input instr_t i);
    return {{20{i.funct7[6]}}, i.funct7, i.rs2};
  endfunction

  // Store offset carries only S-imm[11:5]; the low bits become the shift.
  function automatic logic [31:0] off_s(input instr_t i);
    return {{25{i.funct7[6]}}, i.funct7};
  endfunction

  function automatic logic [4:0] shamt_s(input instr_t i);
    return i.rd;
  endfunction

endpackage

// File: rtl/cv32e40x_if_xif.sv
// XIF issue channel between the CV32E40X core and the FIR coprocessor.
interface cv32e40x_if_xif;
  import fir_xifu_pkg::*;

  logic          issue_valid;
  logic          issue_ready;
  x_issue_req_t  issue_req;
  x_issue_resp_t issue_resp;

  modport coproc_issue (
    input  issue_valid,
    input  issue_req,
    output issue_ready,
    output issue_resp
  );

  modport cpu_issue (
    output issue_valid,
    output issue_req,
    input  issue_ready,
    input  issue_resp
  );

endinterface

// File: rtl/fir_xifu_id_fifo.sv
// Issue queue storage: DEPTH-entry FIFO, head reads '0 when empty.
module fir_xifu_id_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Full comes from the counter alone so a pop never frees a same-cycle push.
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[head_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) tail_q <= wrap_inc(tail_q);
      if (do_pop)  head_q <= wrap_inc(head_q);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[tail_q] <= data_i;
  end

endmodule

// File: rtl/fir_xifu_id_queue.sv
// FIR XIFU decode/issue stage with issue queue and optional scoreboard.
// Define FIR_XIFU_ID_HAZARD_EN to build the pending-write hazard stall.
module fir_xifu_id_queue
  import fir_xifu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREGS = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  cv32e40x_if_xif.coproc_issue     xif_issue_i,
  output id2ex_t                   id2ex_o,
  output logic                     ex_valid_o,
  input  logic                     ex_ready_i,
  input  logic                     wb_valid_i,
  input  logic [$clog2(NREGS)-1:0] wb_rd_i,
  output id2ctrl_t                 id2ctrl_o
);

  localparam int RW = $clog2(NREGS);

  instr_t        ins;
  id2ex_t        entry;
  x_issue_resp_t resp;
  logic          is_op;
  logic          wr_rd;
  logic          use_rd;
  logic          use_rs1;
  logic          use_rs2;
  logic          hazard;
  logic          full;
  logic          empty;
  logic          ready;
  logic          issued;
  logic          unused_rs;

  assign ins   = xif_issue_i.issue_req.instr;
  assign is_op = xif_issue_i.issue_valid &&
                 (ins.opcode == INSTR_OPCODE);

  always_comb begin
    resp         = '0;
    entry        = '0;
    wr_rd        = 1'b0;
    use_rd       = 1'b0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    entry.instr  = ins;
    entry.base   = xif_issue_i.issue_req.rs[0];
    entry.rs1    = ins.rs1;
    entry.rs2    = ins.rs2;
    entry.rd     = ins.rd;
    entry.id     = xif_issue_i.issue_req.id;
    if (is_op) begin
      unique case (1'b1)
        (ins.funct3 == F3_XFIRLW): begin
          resp.accept    = 1'b1;
          resp.writeback = 1'b1;
          resp.loadstore = 1'b1;
          entry.offset   = imm_i(ins);
          wr_rd          = 1'b1;
          use_rd         = 1'b1;
        end
        (ins.funct3 == F3_XFIRSW): begin
          resp.accept    = 1'b1;
          resp.writeback = 1'b1;
          resp.loadstore = 1'b1;
          entry.offset   = off_s(ins);
          entry.shamt    = shamt_s(ins);
          use_rs2        = 1'b1;
        end
        (ins.funct3 == F3_XFIRDOTP): begin
          resp.accept = 1'b1;
          wr_rd       = 1'b1;
          use_rd      = 1'b1;
          use_rs1     = 1'b1;
          use_rs2     = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FIR_XIFU_ID_HAZARD_EN
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;
  logic [RW-1:0]    rs1_x;
  logic [RW-1:0]    rs2_x;
  logic [RW-1:0]    rd_x;

  assign rs1_x = RW'(ins.rs1);
  assign rs2_x = RW'(ins.rs2);
  assign rd_x  = RW'(ins.rd);

  // Reads catch RAW, the rd check catches WAW.
  assign hazard = (use_rs1 && pend_q[rs1_x]) ||
                  (use_rs2 && pend_q[rs2_x]) ||
                  (use_rd  && pend_q[rd_x]);

  always_comb begin
    pend_d = pend_q;
    if (wb_valid_i)      pend_d[wb_rd_i] = 1'b0;
    if (issued && wr_rd) pend_d[rd_x]    = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else if (clear_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  logic unused_wb;
  logic unused_use;

  assign unused_wb  = ^{wb_valid_i, wb_rd_i};
  assign unused_use = ^{wr_rd, use_rd, use_rs1, use_rs2};
  assign hazard     = 1'b0;
`endif

  assign ready  = !full && !hazard;
  assign issued = xif_issue_i.issue_valid && ready && resp.accept;

  assign xif_issue_i.issue_ready = ready;
  assign xif_issue_i.issue_resp  = resp;

  assign id2ctrl_o = '{issue: issued, id: xif_issue_i.issue_req.id};

  assign unused_rs = ^xif_issue_i.issue_req.rs[1];

  fir_xifu_id_fifo #(
    .DEPTH (DEPTH),
    .T     (id2ex_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (issued),
    .data_i  (entry),
    .pop_i   (ex_valid_o && ex_ready_i),
    .data_o  (id2ex_o),
    .full_o  (full),
    .empty_o (empty)
  );

  assign ex_valid_o = !empty;

endmodule

// File: tb/tb_fir_xifu_id_queue.sv
// Directed bench for fir_xifu_id_queue (DEPTH=2), with or without hazard stall.
module tb_fir_xifu_id_queue;
  import fir_xifu_pkg::*;

`ifdef FIR_XIFU_ID_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       clear_i;
  logic       ex_ready_i;
  logic       wb_valid_i;
  logic [4:0] wb_rd_i;
  logic       ex_valid_o;
  id2ex_t     id2ex_o;
  id2ctrl_t   id2ctrl_o;
  int         errors = 0;
  int         checks = 0;

  cv32e40x_if_xif xif ();

  always #5 clk = ~clk;

  fir_xifu_id_queue #(
    .DEPTH (2),
    .NREGS (32)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .xif_issue_i (xif.coproc_issue),
    .id2ex_o     (id2ex_o),
    .ex_valid_o  (ex_valid_o),
    .ex_ready_i  (ex_ready_i),
    .wb_valid_i  (wb_valid_i),
    .wb_rd_i     (wb_rd_i),
    .id2ctrl_o   (id2ctrl_o)
  );

  function automatic logic [31:0] enc_lw(
    input logic [4:0] rd, input logic [11:0] imm
  );
    return {imm, 5'd0, 3'b000, rd, 7'h0B};
  endfunction

  function automatic logic [31:0] enc_sw(
    input logic [4:0] rs2, input logic [11:0] imm
  );
    return {imm[11:5], rs2, 5'd0, 3'b001, imm[4:0], 7'h0B};
  endfunction

  function automatic logic [31:0] enc_dp(
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2
  );
    return {7'd0, rs2, rs1, 3'b010, rd, 7'h0B};
  endfunction

  task automatic chk(
    input string tag, input logic [127:0] got, input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic v, input logic [31:0] ins,
    input logic [31:0] rs0, input logic [3:0] id
  );
    xif.issue_valid        = v;
    xif.issue_req.instr    = ins;
    xif.issue_req.rs[0]    = rs0;
    xif.issue_req.rs[1]    = 32'h0;
    xif.issue_req.id       = id;
    #1;
  endtask

  initial begin
    rst_ni          = 1'b0;
    clear_i         = 1'b0;
    ex_ready_i      = 1'b0;
    wb_valid_i      = 1'b0;
    wb_rd_i         = 5'd0;
    xif.issue_valid = 1'b0;
    xif.issue_req   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_head", id2ex_o, 0);
    chk("rst_ready", xif.issue_ready, 1);
    rst_ni = 1'b1;
    tick;

    // xfirlw x3, 8(0x1000)
    drive(1, enc_lw(5'd3, 12'd8), 32'h1000, 4'd1);
    chk("lw_accept", xif.issue_resp.accept, 1);
    chk("lw_wb", xif.issue_resp.writeback, 1);
    chk("lw_ls", xif.issue_resp.loadstore, 1);
    chk("lw_ctrl_issue", id2ctrl_o.issue, 1);
    chk("lw_ctrl_id", id2ctrl_o.id, 1);
    tick;
    drive(0, 0, 0, 0);
    chk("lw_valid", ex_valid_o, 1);
    chk("lw_base", id2ex_o.base, 32'h1000);
    chk("lw_off", id2ex_o.offset, 32'd8);
    chk("lw_rd", id2ex_o.rd, 3);
    chk("lw_shamt", id2ex_o.shamt, 0);
    ex_ready_i = 1'b1;
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd3;
    tick;
    ex_ready_i = 1'b0;
    wb_valid_i = 1'b0;
    chk("lw_popped", ex_valid_o, 0);

    // xfirsw x7 with imm 0xFE4
    drive(1, enc_sw(5'd7, 12'hFE4), 32'h2000, 4'd2);
    chk("sw_accept", xif.issue_resp.accept, 1);
    chk("sw_wb", xif.issue_resp.writeback, 1);
    chk("sw_ls", xif.issue_resp.loadstore, 1);
    tick;
    drive(0, 0, 0, 0);
    chk("sw_off", id2ex_o.offset, 32'hFFFF_FFFF);
    chk("sw_shamt", id2ex_o.shamt, 4);
    chk("sw_rs2", id2ex_o.rs2, 7);
    chk("sw_base", id2ex_o.base, 32'h2000);
    ex_ready_i = 1'b1;
    tick;
    ex_ready_i = 1'b0;

    // fill, stall on full, wrap
    drive(1, enc_dp(5'd10, 5'd11, 5'd12), 0, 4'd3);
    chk("fill0_ready", xif.issue_ready, 1);
    tick;
    drive(1, enc_dp(5'd13, 5'd14, 5'd15), 0, 4'd4);
    chk("fill1_ready", xif.issue_ready, 1);
    tick;
    drive(1, enc_dp(5'd16, 5'd17, 5'd18), 0, 4'd5);
    chk("full_ready", xif.issue_ready, 0);
    chk("full_issue", id2ctrl_o.issue, 0);
    ex_ready_i = 1'b1;
    #1;
    chk("full_ready_exr", xif.issue_ready, 0);
    tick;
    chk("wrap_head1", id2ex_o.id, 4);
    ex_ready_i = 1'b0;
    #1;
    chk("wrap_ready", xif.issue_ready, 1);
    tick;
    drive(0, 0, 0, 0);
    chk("wrap_valid", ex_valid_o, 1);
    chk("wrap_head2", id2ex_o.id, 4);
    ex_ready_i = 1'b1;
    tick;
    chk("wrap_head3", id2ex_o.id, 5);
    chk("wrap_rd3", id2ex_o.rd, 16);
    tick;
    chk("drained", ex_valid_o, 0);
    ex_ready_i = 1'b0;

    // unsupported funct3 and foreign opcode
    drive(1, {17'd0, 3'b111, 5'd1, 7'h0B}, 0, 4'd6);
    chk("bad_accept", xif.issue_resp.accept, 0);
    chk("bad_issue", id2ctrl_o.issue, 0);
    chk("bad_id", id2ctrl_o.id, 6);
    chk("bad_ready", xif.issue_ready, 1);
    tick;
    drive(1, {17'd0, 3'b000, 5'd1, 7'h33}, 0, 4'd6);
    chk("bad_nopush", ex_valid_o, 0);
    chk("opc_accept", xif.issue_resp.accept, 0);
    tick;
    chk("opc_nopush", ex_valid_o, 0);

    // RAW on x5
    ex_ready_i = 1'b1;
    drive(1, enc_lw(5'd5, 12'd0), 32'h3000, 4'd7);
    tick;
    drive(1, enc_dp(5'd1, 5'd5, 5'd2), 0, 4'd8);
`ifdef FIR_XIFU_ID_HAZARD_EN
    chk("raw_stall", xif.issue_ready, 0);
    tick;
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd5;
    #1;
    chk("raw_nobypass", xif.issue_ready, 0);
    tick;
    wb_valid_i = 1'b0;
    #1;
    chk("raw_release", xif.issue_ready, 1);
`else
    chk("raw_nostall", xif.issue_ready, 1);
`endif
    chk("raw_issue", id2ctrl_o.issue, 1);
    tick;

    // set and clear of x5 in one cycle
    drive(1, enc_lw(5'd5, 12'd0), 0, 4'd9);
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd5;
    #1;
    chk("setclr_ready", xif.issue_ready, 1);
    tick;
    wb_valid_i = 1'b0;
    ex_ready_i = 1'b0;
    drive(1, enc_dp(5'd20, 5'd5, 5'd21), 0, 4'd10);
    chk("setwins_ready", xif.issue_ready, !HZ);
    drive(1, enc_lw(5'd22, 12'd0), 0, 4'd11);
    chk("indep_ready", xif.issue_ready, 1);
    tick;
    chk("preclr_valid", ex_valid_o, 1);
    chk("preclr_full", xif.issue_ready, 0);

    // flush
    drive(0, 0, 0, 0);
    clear_i = 1'b1;
    tick;
    clear_i = 1'b0;
    chk("clr_valid", ex_valid_o, 0);
    chk("clr_head", id2ex_o, 0);
    drive(1, enc_dp(5'd20, 5'd5, 5'd21), 0, 4'd12);
    chk("clr_dep_ready", xif.issue_ready, 1);
    tick;
    drive(0, 0, 0, 0);
    chk("post_clr_head", id2ex_o.id, 12);
    clear_i = 1'b1;
    drive(1, enc_lw(5'd24, 12'd0), 0, 4'd13);
    chk("clr_report", id2ctrl_o.issue, 1);
    tick;
    clear_i = 1'b0;
    drive(0, 0, 0, 0);
    chk("clr_drop", ex_valid_o, 0);
    drive(1, enc_dp(5'd24, 5'd24, 5'd24), 0, 4'd14);
    chk("clr_drop_sb", xif.issue_ready, 1);
    tick;
    drive(0, 0, 0, 0);
    chk("pre_arst_valid", ex_valid_o, 1);

    // asynchronous reset mid-cycle
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", ex_valid_o, 0);
    chk("arst_head", id2ex_o, 0);
    rst_ni = 1'b1;
    tick;
    chk("arst_ready", xif.issue_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
